// File: rtl/uart_interface_pkg.sv
// Shared constants, state types and helpers for the uart_interface peripheral.
// Register addresses are the decoded addr_i[2:0] values.
package uart_interface_pkg;

    localparam logic [2:0] ADDR_RXDATA = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd3;
    localparam logic [2:0] ADDR_BAUD   = 3'd4;
    localparam logic [2:0] ADDR_FLAGS  = 3'd5;
    localparam logic [2:0] ADDR_TXBUF  = 3'd7;

    localparam logic [2:0] CTRL_START    = 3'd7;
    localparam logic [2:0] CTRL_TX_EN    = 3'd6;
    localparam logic [2:0] CTRL_RX_EN    = 3'd5;
    localparam logic [2:0] CTRL_TX_SRST  = 3'd3;
    localparam logic [2:0] CTRL_RX_VALID = 3'd1;
    localparam logic [2:0] CTRL_TX_READY = 3'd0;

    localparam logic [1:0] FLAG_TX_DONE   = 2'd0;
    localparam logic [1:0] FLAG_RX_VALID  = 2'd1;
    localparam logic [1:0] FLAG_RX_OVERRUN = 2'd2;
    localparam logic [1:0] FLAG_FRAME_ERR = 2'd3;

    // Half-scale preset so RX carries land in the middle of each bit.
    localparam logic [31:0] RX_PRESET = 32'h8000_0000;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    function automatic logic [7:0] sel_byte(input logic [31:0] dat, input logic [3:0] sel);
        logic [7:0] b;
        if (sel[0]) begin
            b = dat[7:0];
        end else if (sel[1]) begin
            b = dat[15:8];
        end else if (sel[2]) begin
            b = dat[23:16];
        end else if (sel[3]) begin
            b = dat[31:24];
        end else begin
            b = 8'h00;
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_interface_baud_acc.sv
// 32-bit phase accumulator; the carry-out of each add is one bit-rate tick.
// Clear zeroes the phase, preset loads the mid-bit phase; neither produces a tick.
module uart_baud_acc
    import uart_interface_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] inc_i,
    input  logic        clear_i,
    input  logic        preset_i,
    output logic        tick_o
);

    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [32:0] sum_s;

    // Next phase and carry tick.
    always_comb begin
        sum_s = {1'b0, acc_q} + {1'b0, inc_i};
        if (clear_i) begin
            acc_d  = 32'h0000_0000;
            tick_o = 1'b0;
        end else if (preset_i) begin
            acc_d  = RX_PRESET;
            tick_o = 1'b0;
        end else begin
            acc_d  = sum_s[31:0];
            tick_o = sum_s[32];
        end
    end

    // Phase register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= 32'h0000_0000;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/uart_interface.sv
// Bus-attached 8N1 UART: register file, TX and RX state machines, and two
// phase-accumulator baud generators sharing one programmed increment.
module uart_interface
    import uart_interface_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] BAUD_RST = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] dat_i,
    output logic [DATA_W-1:0] dat_o,
    input  logic              we_i,
    input  logic [3:0]        sel_i,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              lock_i,
    output logic              err_o,
    output logic              rty_o,
    output logic              ack_o,
    input  logic              tagn_i,
    output logic              tagn_o,
    input  logic              uart_rx,
    output logic              uart_tx,
    input  logic              tx_ready_inhibitor
);

    logic              unused_s;
    logic [2:0]        addr_s;
    logic              wr_s, ctrl_wr_s, baud_wr_s, flags_wr_s, txbuf_wr_s, rxdata_rd_s;
    logic              rsvd_s, tx_srst_s, tx_busy_s;
    logic              tx_tick_s, rx_tick_s, rx_preset_s, rx_s_s, rx_fall_s;
    logic [DATA_W-1:0] rdata_s;

    logic [31:0]       baud_q;
    logic [7:0]        txbuf_q;
    logic              tx_en_q, rx_en_q;
    logic              ack_q, err_q, tagn_q;
    logic [DATA_W-1:0] dat_q;
    logic [2:0]        rx_sync_q;

    tx_state_e         tx_state_q, tx_state_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic [2:0]        tx_cnt_q, tx_cnt_d;
    logic              tx_line_q, tx_line_d;
    logic              tx_done_q, tx_done_d;
    logic              start_q, start_d;

    rx_state_e         rx_state_q, rx_state_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic [2:0]        rx_cnt_q, rx_cnt_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              overrun_q, overrun_d;
    logic              frame_err_q, frame_err_d;

    assign unused_s    = ^{cyc_i, lock_i, addr_i[ADDR_W-1:3]};
    assign addr_s      = addr_i[2:0];
    assign wr_s        = stb_i & we_i;
    assign ctrl_wr_s   = wr_s & (addr_s == ADDR_CTRL);
    assign baud_wr_s   = wr_s & (addr_s == ADDR_BAUD);
    assign flags_wr_s  = wr_s & (addr_s == ADDR_FLAGS);
    assign txbuf_wr_s  = wr_s & (addr_s == ADDR_TXBUF);
    assign rxdata_rd_s = stb_i & ~we_i & (addr_s == ADDR_RXDATA);
    assign rsvd_s      = (addr_s == 3'd0) | (addr_s == 3'd2) | (addr_s == 3'd6);
    assign tx_srst_s   = ctrl_wr_s & dat_i[CTRL_TX_SRST];
    assign tx_busy_s   = (tx_state_q != TX_IDLE);
    assign rx_s_s      = rx_sync_q[1];
    assign rx_fall_s   = rx_sync_q[2] & ~rx_sync_q[1];

    uart_baud_acc u_tx_acc (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (baud_q),
        .clear_i  (baud_wr_s | tx_srst_s),
        .preset_i (1'b0),
        .tick_o   (tx_tick_s)
    );

    uart_baud_acc u_rx_acc (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (baud_q),
        .clear_i  (baud_wr_s),
        .preset_i (rx_preset_s),
        .tick_o   (rx_tick_s)
    );

    // Read data mux; values reflect state before the access edge.
    always_comb begin
        rdata_s = '0;
        case (addr_s)
            ADDR_RXDATA: rdata_s[7:0]  = rx_data_q;
            ADDR_CTRL:   rdata_s[7:0]  = {start_q | tx_busy_s, tx_en_q, rx_en_q, 3'b000,
                                          rx_valid_q, ~tx_busy_s & ~tx_ready_inhibitor};
            ADDR_BAUD:   rdata_s[31:0] = baud_q;
            ADDR_FLAGS:  rdata_s[3:0]  = {frame_err_q, overrun_q, rx_valid_q, tx_done_q};
            ADDR_TXBUF:  rdata_s[7:0]  = txbuf_q;
            default:     rdata_s       = '0;
        endcase
    end

    // Software-written configuration registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            baud_q  <= BAUD_RST;
            txbuf_q <= 8'h00;
            tx_en_q <= 1'b0;
            rx_en_q <= 1'b0;
        end else begin
            if (baud_wr_s) baud_q <= dat_i[31:0];
            if (txbuf_wr_s && (sel_i != 4'b0000)) txbuf_q <= sel_byte(dat_i[31:0], sel_i);
            if (ctrl_wr_s) begin
                tx_en_q <= dat_i[CTRL_TX_EN];
                rx_en_q <= dat_i[CTRL_RX_EN];
            end
        end
    end

    // Single-cycle bus response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            tagn_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            ack_q  <= stb_i;
            err_q  <= stb_i & rsvd_s;
            tagn_q <= stb_i & tagn_i;
            dat_q  <= stb_i ? rdata_s : '0;
        end
    end

    // TX next-state: frame sequencing, then soft reset/START overrides.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_line_d  = tx_line_q;
        tx_done_d  = flags_wr_s ? 1'b0 : tx_done_q;
        start_d    = start_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_tick_s && start_q && tx_en_q) begin
                    tx_state_d = TX_START;
                    tx_shift_d = txbuf_q;
                    tx_line_d  = 1'b0;
                    start_d    = 1'b0;
                end else begin
                    tx_line_d  = 1'b1;
                end
            end
            TX_START: begin
                if (tx_tick_s) begin
                    tx_state_d = TX_DATA;
                    tx_line_d  = tx_shift_q[0];
                    tx_cnt_d   = 3'd0;
                end else begin
                    tx_state_d = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_tick_s && (tx_cnt_q == 3'd7)) begin
                    tx_state_d = TX_STOP;
                    tx_line_d  = 1'b1;
                end else if (tx_tick_s) begin
                    tx_cnt_d   = tx_cnt_q + 3'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_line_d  = tx_shift_q[1];
                end else begin
                    tx_state_d = TX_DATA;
                end
            end
            TX_STOP: begin
                if (tx_tick_s) begin
                    tx_state_d = TX_IDLE;
                    tx_done_d  = 1'b1;
                    start_d    = 1'b0;
                end else begin
                    tx_state_d = TX_STOP;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_line_d  = 1'b1;
            end
        endcase
        if (tx_srst_s) begin
            tx_state_d = TX_IDLE;
            tx_line_d  = 1'b1;
            start_d    = 1'b0;
            tx_done_d  = 1'b0;
        end else begin
            // START is only accepted while the transmitter stays idle.
            start_d = !ctrl_wr_s ? start_d :
                      (tx_state_d == TX_IDLE) ? dat_i[CTRL_START] : 1'b0;
        end
    end

    // TX state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= 8'h00;
            tx_cnt_q   <= 3'd0;
            tx_line_q  <= 1'b1;
            tx_done_q  <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_line_q  <= tx_line_d;
            tx_done_q  <= tx_done_d;
            start_q    <= start_d;
        end
    end

    // RX next-state: bus clears first so a completing frame wins.
    always_comb begin
        rx_state_d  = rx_state_q;
        rx_shift_d  = rx_shift_q;
        rx_cnt_d    = rx_cnt_q;
        rx_data_d   = rx_data_q;
        rx_preset_s = 1'b0;
        rx_valid_d  = (rxdata_rd_s | flags_wr_s) ? 1'b0 : rx_valid_q;
        overrun_d   = flags_wr_s ? 1'b0 : overrun_q;
        frame_err_d = flags_wr_s ? 1'b0 : frame_err_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_en_q && rx_fall_s) begin
                    rx_preset_s = 1'b1;
                    rx_state_d  = RX_START;
                end else begin
                    rx_state_d  = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_tick_s) begin
                    rx_state_d = rx_s_s ? RX_IDLE : RX_DATA;
                    rx_cnt_d   = 3'd0;
                end else begin
                    rx_state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_tick_s) begin
                    rx_shift_d = {rx_s_s, rx_shift_q[7:1]};
                    rx_cnt_d   = rx_cnt_q + 3'd1;
                    rx_state_d = (rx_cnt_q == 3'd7) ? RX_STOP : RX_DATA;
                end else begin
                    rx_state_d = RX_DATA;
                end
            end
            RX_STOP: begin
                if (rx_tick_s && rx_s_s) begin
                    rx_state_d = RX_IDLE;
                    rx_data_d  = rx_shift_q;
                    overrun_d  = overrun_d | rx_valid_d;
                    rx_valid_d = 1'b1;
                end else if (rx_tick_s) begin
                    rx_state_d  = RX_IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    rx_state_d  = RX_STOP;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
        rx_state_d = rx_en_q ? rx_state_d : RX_IDLE;
    end

    // RX synchroniser and state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_sync_q   <= 3'b111;
            rx_state_q  <= RX_IDLE;
            rx_shift_q  <= 8'h00;
            rx_cnt_q    <= 3'd0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_sync_q   <= {rx_sync_q[1:0], uart_rx};
            rx_state_q  <= rx_state_d;
            rx_shift_q  <= rx_shift_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign dat_o   = dat_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign rty_o   = 1'b0;
    assign tagn_o  = tagn_q;
    assign uart_tx = tx_line_q;

endmodule

// File: tb/tb_uart_interface.sv
// Scoreboard bench for uart_interface: bus responses and TX frames are checked
// by independent monitors against expectations queued by the stimulus.
module tb_uart_interface;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, dat_in;
    logic [31:0] dat_out;
    logic        we, stb, cyc, lock, tagn_in;
    logic [3:0]  sel;
    logic        err, rty, ack, tagn_out;
    logic        uart_rx, uart_tx, inhibit;

    always #5 clk = ~clk;

    uart_interface dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .addr_i             (addr),
        .dat_i              (dat_in),
        .dat_o              (dat_out),
        .we_i               (we),
        .sel_i              (sel),
        .cyc_i              (cyc),
        .stb_i              (stb),
        .lock_i             (lock),
        .err_o              (err),
        .rty_o              (rty),
        .ack_o              (ack),
        .tagn_i             (tagn_in),
        .tagn_o             (tagn_out),
        .uart_rx            (uart_rx),
        .uart_tx            (uart_tx),
        .tx_ready_inhibitor (inhibit)
    );

    typedef struct packed {
        logic        chk_dat;
        logic        exp_err;
        logic        exp_tag;
        logic [31:0] exp_dat;
    } bus_exp_t;

    bus_exp_t   bus_q[$];
    logic [7:0] tx_q[$];
    int         checks = 0;
    int         errors = 0;
    int         tx_frames = 0;
    logic       tx_mon_en = 1'b1;
    logic       tx_prev = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_xfer(input logic [2:0] a, input logic w, input logic [31:0] d,
                            input logic [3:0] s, input logic chk, input logic [31:0] exp,
                            input logic exp_err);
        bus_exp_t e;
        @(negedge clk);
        addr    = {29'd0, a};
        we      = w;
        dat_in  = d;
        sel     = s;
        stb     = 1'b1;
        tagn_in = ~tagn_in;
        e.chk_dat = chk;
        e.exp_err = exp_err;
        e.exp_tag = tagn_in;
        e.exp_dat = exp;
        bus_q.push_back(e);
        @(negedge clk);
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic exp_err);
        bus_xfer(a, 1'b1, d, 4'b1111, 1'b0, 32'd0, exp_err);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input logic exp_err);
        bus_xfer(a, 1'b0, 32'd0, 4'b0000, 1'b1, exp, exp_err);
    endtask

    task automatic send_frame(input logic [7:0] b);
        tx_q.push_back(b);
        wr(3'd3, 32'h0000_00E0, 1'b0);
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 300 && tx_frames < n; i++) @(negedge clk);
        check("tx_frame_count", 32'(tx_frames), 32'(n));
        repeat (6) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (4) @(negedge clk);
        end
        uart_rx = stop;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Bus response monitor.
    initial begin
        bus_exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && ack === 1'b1) begin
                if (bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack with dat_o 0x%08h, expected no ack", dat_out);
                end else begin
                    e = bus_q.pop_front();
                    check("ack_err", 32'(err), 32'(e.exp_err));
                    check("ack_tag", 32'(tagn_out), 32'(e.exp_tag));
                    check("ack_rty", 32'(rty), 32'd0);
                    if (e.chk_dat) check("rdata", dat_out, e.exp_dat);
                end
            end else if (rst === 1'b0 && err !== 1'b0) begin
                check("err_without_ack", 32'(err), 32'd0);
            end
        end
    end

    // Serial TX monitor: samples each bit near its middle.
    initial begin
        logic [7:0] b;
        logic [7:0] e;
        logic       s0, s1;
        forever begin
            @(negedge clk);
            if (tx_mon_en && rst === 1'b0 && tx_prev === 1'b1 && uart_tx === 1'b0) begin
                repeat (2) @(negedge clk);
                s0 = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (4) @(negedge clk);
                s1 = uart_tx;
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected_frame: got byte 0x%02h, expected no frame", b);
                end else begin
                    e = tx_q.pop_front();
                    check("tx_start_bit", 32'(s0), 32'd0);
                    check("tx_data", 32'(b), 32'(e));
                    check("tx_stop_bit", 32'(s1), 32'd1);
                end
                tx_frames++;
            end
            tx_prev = uart_tx;
        end
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int zeros;
        rst = 1'b1; stb = 1'b0; we = 1'b0; cyc = 1'b0; lock = 1'b0;
        addr = 32'd0; dat_in = 32'd0; sel = 4'b0000; tagn_in = 1'b0;
        uart_rx = 1'b1; inhibit = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rty", 32'(rty), 32'd0);
        check("rst_tagn", 32'(tagn_out), 32'd0);
        check("rst_dat", dat_out, 32'd0);
        rst = 1'b0;

        rd(3'd3, 32'h0000_0001, 1'b0);
        rd(3'd4, 32'h0000_0000, 1'b0);
        wr(3'd4, 32'h4000_0000, 1'b0);
        rd(3'd4, 32'h4000_0000, 1'b0);
        bus_xfer(3'd7, 1'b1, 32'h6162_6364, 4'b0001, 1'b0, 32'd0, 1'b0);
        rd(3'd7, 32'h0000_0064, 1'b0);
        wr(3'd3, 32'h0000_0068, 1'b0);
        rd(3'd3, 32'h0000_0061, 1'b0);

        send_frame(8'h64);
        wait_tx(1);
        rd(3'd5, 32'h0000_0001, 1'b0);
        rd(3'd3, 32'h0000_0061, 1'b0);

        bus_xfer(3'd7, 1'b1, 32'h6162_6364, 4'b0010, 1'b0, 32'd0, 1'b0);
        rd(3'd7, 32'h0000_0063, 1'b0);
        send_frame(8'h63);
        wait_tx(2);
        bus_xfer(3'd7, 1'b1, 32'h6162_6364, 4'b0100, 1'b0, 32'd0, 1'b0);
        send_frame(8'h62);
        wait_tx(3);
        bus_xfer(3'd7, 1'b1, 32'h6162_6364, 4'b1000, 1'b0, 32'd0, 1'b0);
        send_frame(8'h61);
        wait_tx(4);
        bus_xfer(3'd7, 1'b1, 32'h0000_0000, 4'b0000, 1'b0, 32'd0, 1'b0);
        rd(3'd7, 32'h0000_0061, 1'b0);

        wr(3'd5, 32'h0000_0000, 1'b0);
        rd(3'd5, 32'h0000_0000, 1'b0);
        rd(3'd3, 32'h0000_0061, 1'b0);
        inhibit = 1'b1;
        rd(3'd3, 32'h0000_0060, 1'b0);
        inhibit = 1'b0;

        // Soft reset in the middle of a 0x61 frame (bit1 and bit2 are 0).
        tx_mon_en = 1'b0;
        wr(3'd3, 32'h0000_00E0, 1'b0);
        for (int i = 0; i < 40 && uart_tx !== 1'b0; i++) @(negedge clk);
        check("abort_start_seen", 32'(uart_tx), 32'd0);
        repeat (10) @(negedge clk);
        check("abort_pre_line", 32'(uart_tx), 32'd0);
        wr(3'd3, 32'h0000_0068, 1'b0);
        check("abort_line_high", 32'(uart_tx), 32'd1);
        zeros = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) zeros++;
        end
        check("abort_line_idle", 32'(zeros), 32'd0);
        rd(3'd5, 32'h0000_0000, 1'b0);
        rd(3'd3, 32'h0000_0061, 1'b0);
        tx_mon_en = 1'b1;

        send_rx(8'h5A, 1'b1);
        rd(3'd5, 32'h0000_0002, 1'b0);
        rd(3'd3, 32'h0000_0063, 1'b0);
        rd(3'd1, 32'h0000_005A, 1'b0);
        rd(3'd5, 32'h0000_0000, 1'b0);
        send_rx(8'hA5, 1'b1);
        send_rx(8'h3C, 1'b1);
        rd(3'd5, 32'h0000_0006, 1'b0);
        rd(3'd1, 32'h0000_003C, 1'b0);
        rd(3'd5, 32'h0000_0004, 1'b0);
        wr(3'd5, 32'h0000_0000, 1'b0);
        send_rx(8'h81, 1'b0);
        rd(3'd5, 32'h0000_0008, 1'b0);
        rd(3'd1, 32'h0000_003C, 1'b0);

        rd(3'd0, 32'h0000_0000, 1'b1);
        rd(3'd2, 32'h0000_0000, 1'b1);
        rd(3'd6, 32'h0000_0000, 1'b1);
        wr(3'd2, 32'hFFFF_FFFF, 1'b1);

        repeat (4) @(negedge clk);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
